// File: rtl/imem_port_arbiter_if.sv
// +------------------------------------------------------------------------+
// | imem_port_arbiter_if                                                    |
// | Fetch/data requester handshakes plus the byte-wide memory port.         |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
`default_nettype none

interface imem_port_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int MEM_AW = 10
);
  logic              if_req;
  logic [WIDTH-1:0]  if_addr;
  logic              if_ack;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic              d_we;
  logic [WIDTH-1:0]  d_addr;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic [31:0]       d_rdata;

  logic              err;
  logic              busy;

  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, err, busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requesters and memory side
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, err, busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/imem_port_arbiter.sv
// +------------------------------------------------------------------------+
// | imem_port_arbiter                                                       |
// | Round-robin share of one byte-wide sync RAM between fetch and LSU;      |
// | each 32-bit access is four big-endian byte cycles.                      |
// | Optional: IMEM_ARB_ALIGN_CHECK_EN rejects misaligned addresses (err).   |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
`default_nettype none

module imem_port_arbiter #(
  parameter int WIDTH  = 32,
  parameter int MEM_AW = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  imem_port_arbiter_if.slave     bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_TAIL = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]  base_q, base_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              sel_data_q, sel_data_d;
  logic              last_data_q, last_data_d;
  logic [23:0]       sh_q, sh_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;

  logic              w_pick_data;
  logic [WIDTH-1:0]  w_req_addr;
  logic              w_misalign;
  logic [1:0]        w_cnt_inc;
  logic [WIDTH-1:0]  w_next_addr;

  // Data wins only when fetch is idle or fetch was the last one served.
  assign w_pick_data = bus.d_req && (!bus.if_req || !last_data_q);
  assign w_req_addr  = w_pick_data ? bus.d_addr : bus.if_addr;
  assign w_cnt_inc   = cnt_q + 2'd1;
  assign w_next_addr = base_q + {{(WIDTH-2){1'b0}}, w_cnt_inc};

`ifdef IMEM_ARB_ALIGN_CHECK_EN
  assign w_misalign = (w_req_addr[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    sel_data_d  = sel_data_q;
    last_data_d = last_data_q;
    sh_d        = sh_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.if_req || bus.d_req) begin
          sel_data_d  = w_pick_data;
          last_data_d = w_pick_data;
          base_d      = w_req_addr;
          we_d        = w_pick_data && bus.d_we;
          wdata_d     = bus.d_wdata;
          cnt_d       = 2'd0;
          if (w_misalign) begin
            state_d  = S_RESP;
            err_d    = 1'b1;
            if_ack_d = !w_pick_data;
            d_ack_d  = w_pick_data;
          end else begin
            state_d     = S_XFER;
            mem_en_d    = 1'b1;
            mem_we_d    = w_pick_data && bus.d_we;
            mem_addr_d  = w_req_addr[MEM_AW-1:0];
            mem_wdata_d = bus.d_wdata[31:24];
          end
        end
      end

      S_XFER: begin
        // Read data lags the address by one cycle, so byte 0 lands at cnt=1.
        if (!we_q && (cnt_q != 2'd0)) begin
          sh_d = {sh_q[15:0], bus.mem_rdata};
        end
        if (cnt_q != 2'd3) begin
          cnt_d       = w_cnt_inc;
          mem_en_d    = 1'b1;
          mem_we_d    = we_q;
          mem_addr_d  = w_next_addr[MEM_AW-1:0];
          mem_wdata_d = wdata_q[23:16];
          wdata_d     = {wdata_q[23:0], 8'h00};
        end else if (we_q) begin
          state_d  = S_RESP;
          if_ack_d = !sel_data_q;
          d_ack_d  = sel_data_q;
        end else begin
          state_d = S_TAIL;
        end
      end

      S_TAIL: begin
        state_d = S_RESP;
        if (sel_data_q) begin
          d_ack_d   = 1'b1;
          d_rdata_d = {sh_q, bus.mem_rdata};
        end else begin
          if_ack_d   = 1'b1;
          if_rdata_d = {sh_q, bus.mem_rdata};
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      base_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= 32'h0;
      sel_data_q  <= 1'b0;
      last_data_q <= 1'b1;
      sh_q        <= 24'h0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h0;
      if_rdata_q  <= 32'h0;
      d_rdata_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      sel_data_q  <= sel_data_d;
      last_data_q <= last_data_d;
      sh_q        <= sh_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
// +------------------------------------------------------------------------+
// | tb_imem_port_arbiter                                                    |
// | Self-checking bench: vector table, corner sequences, random traffic.    |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_imem_port_arbiter;

`ifdef IMEM_ARB_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk;
  logic rst;

  imem_port_arbiter_if #(.WIDTH(32), .MEM_AW(10)) bus ();

  imem_port_arbiter #(.WIDTH(32), .MEM_AW(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-wide synchronous RAM
  logic [7:0] ram [0:1023];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  // Memory-cycle log and ack exclusivity monitor, sampled mid-cycle
  logic [9:0] acc_addr [$];
  bit         acc_we   [$];
  bit         both_ack_seen = 1'b0;
  always @(negedge clk) begin
    if (!rst && bus.mem_en) begin
      acc_addr.push_back(bus.mem_addr);
      acc_we.push_back(bus.mem_we);
    end
    if (bus.if_ack && bus.d_ack) both_ack_seen = 1'b1;
  end

  // Reference model: flat byte array and the rdata each port should present
  logic [7:0]  ref_mem [0:1023];
  logic [31:0] exp_if_rd;
  logic [31:0] exp_d_rd;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] x;
    w = 32'h0;
    for (int i = 0; i < 4; i++) begin
      x = a + i;
      w = {w[23:0], ref_mem[x[9:0]]};
    end
    return w;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] x;
    for (int i = 0; i < 4; i++) begin
      x = a + i;
      ref_mem[x[9:0]] = wd[31-8*i -: 8];
    end
  endtask

  function automatic bit seq_ok(input logic [31:0] a, input bit we, input int n);
    logic [31:0] x;
    if (acc_addr.size() != n) return 1'b0;
    for (int i = 0; i < n; i++) begin
      x = a + i;
      if (acc_addr[i] != x[9:0] || acc_we[i] != we) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic drop_reqs();
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
  endtask

  // Single-requester access; latency counted in cycles after the grant cycle.
  task automatic do_access(input bit port, input bit we, input logic [31:0] addr,
                           input logic [31:0] wd, output int lat,
                           output logic [31:0] rd, output logic er, output int busy_n);
    logic ack;
    acc_addr.delete();
    acc_we.delete();
    lat = -1; busy_n = 0; rd = 32'h0; er = 1'b0;
    if (port) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wd;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (bus.busy) busy_n++;
      ack = port ? bus.d_ack : bus.if_ack;
      if (ack) begin
        lat = k;
        er  = bus.err;
        rd  = port ? bus.d_rdata : bus.if_rdata;
        drop_reqs();
      end
    end
    drop_reqs();
    @(posedge clk); #1;
    if (bus.busy) busy_n++;
  endtask

  task automatic verify(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input int exp_lat, input bit exp_err, input string tag);
    int          lat;
    int          busy_n;
    logic [31:0] rd;
    logic        er;
    do_access(port, we, addr, wd, lat, rd, er, busy_n);
    chk({tag, "_lat"},   lat,    exp_lat);
    chk({tag, "_rdata"}, rd,     exp_rd);
    chk({tag, "_err"},   er,     exp_err);
    chk({tag, "_busy"},  busy_n, exp_lat);
    chk({tag, "_memseq"}, seq_ok(addr, we, exp_err ? 0 : 4), 1);
    if (!exp_err && we) ref_write(addr, wd);
    if (port) exp_d_rd  = exp_rd;
    else      exp_if_rd = exp_rd;
  endtask

  task automatic model_verify(input bit port, input bit we, input logic [31:0] addr,
                              input logic [31:0] wd, input string tag);
    bit          e;
    int          l;
    logic [31:0] r;
    e = ALIGN && (addr[1:0] != 2'b00);
    l = e ? 1 : (we ? 5 : 6);
    r = port ? exp_d_rd : exp_if_rd;
    if (!e && !we) r = ref_word(addr);
    verify(port, we, addr, wd, r, l, e, tag);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_if_rd = 32'h0;
    exp_d_rd  = 32'h0;
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
    bit          exp_err;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int   if_k, d_k, nack;
    logic [3:0] ord;
    bit   ack_in_rst;

    tbl[0] = '{1'b1, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        5, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 6, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 32'h3FC, 32'hAABBCCDD, 32'h0,        5, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 32'h000, 32'h11223344, 32'h0,        5, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 32'h3FC, 32'h0,        32'hAABBCCDD, 6, 1'b0};
    if (ALIGN) tbl[5] = '{1'b0, 1'b0, 32'h3FE, 32'h0, 32'hDEADBEEF, 1, 1'b1};
    else       tbl[5] = '{1'b0, 1'b0, 32'h3FE, 32'h0, 32'hCCDD1122, 6, 1'b0};

    for (int i = 0; i < 1024; i++) ref_mem[i] = ram[i];
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    exp_if_rd = 32'h0; exp_d_rd = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {26'h0, bus.if_ack, bus.d_ack, bus.err, bus.busy, bus.mem_en, bus.mem_we}, 32'h0);
    chk("reset_mem_bus", {14'h0, bus.mem_addr, bus.mem_wdata}, 32'h0);
    chk("reset_rdata", bus.if_rdata | bus.d_rdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      verify(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata,
             tbl[i].exp_rd, tbl[i].exp_lat, tbl[i].exp_err, $sformatf("vec%0d", i));
      if (i == 0) chk("ram_0x10", {ram[16], ram[17], ram[18], ram[19]}, 32'hDEADBEEF);
    end

    // Simultaneous requests straight out of reset: fetch first
    pulse_reset();
    if_k = -1; d_k = -1;
    bus.if_req = 1'b1; bus.if_addr = 32'h30;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
    for (int k = 1; k <= 30 && d_k < 0; k++) begin
      @(posedge clk); #1;
      if (bus.if_ack) begin
        if_k = k; bus.if_req = 1'b0;
        chk("tie_if_rdata", bus.if_rdata, ref_word(32'h30));
      end
      if (bus.d_ack) begin
        d_k = k; bus.d_req = 1'b0;
        chk("tie_d_rdata", bus.d_rdata, ref_word(32'h20));
      end
    end
    drop_reqs();
    chk("tie_if_ack_cycle", if_k, 6);
    chk("tie_d_ack_cycle", d_k, 13);
    repeat (3) @(posedge clk); #1;

    // Continuous contention: grants must alternate
    ord = 4'h0; nack = 0;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h3FC;
    for (int k = 0; k < 80 && nack < 4; k++) begin
      @(posedge clk); #1;
      if (bus.if_ack || bus.d_ack) begin
        ord = {ord[2:0], bus.d_ack};
        nack++;
        if (nack == 4) drop_reqs();
      end
    end
    drop_reqs();
    chk("rr_ack_count", nack, 4);
    chk("rr_order", ord, 4'b0101);
    repeat (10) @(posedge clk); #1;

    // Reset in the middle of a write
    acc_addr.delete(); acc_we.delete();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_ctrl", {26'h0, bus.if_ack, bus.d_ack, bus.err, bus.busy, bus.mem_en, bus.mem_we}, 32'h0);
    chk("midrst_mem_bus", {14'h0, bus.mem_addr, bus.mem_wdata}, 32'h0);
    chk("midrst_rdata", bus.if_rdata | bus.d_rdata, 32'h0);
    drop_reqs();
    ack_in_rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k == 2) rst = 1'b0;
      if (bus.if_ack || bus.d_ack) ack_in_rst = 1'b1;
    end
    chk("midrst_no_ack", ack_in_rst, 1'b0);
    exp_if_rd = 32'h0; exp_d_rd = 32'h0;
    model_verify(1'b1, 1'b1, 32'h40, 32'h0BADF00D, "post_rst_wr");
    model_verify(1'b0, 1'b0, 32'h40, 32'h0, "post_rst_fetch");

    // Random single-requester traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      bit          p, w;
      logic [31:0] a, d;
      p = $urandom_range(0, 1);
      w = p && $urandom_range(0, 1);
      a = $urandom;
      if ($urandom_range(0, 1)) a[1:0] = 2'b00;
      d = $urandom;
      model_verify(p, w, a, d, $sformatf("rnd%0d", i));
    end

    chk("ack_exclusive", both_ack_seen, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
